// File: rtl/arith_ext_arb_pkg.sv
// Shared types and helpers for the width-extension arbiter.
// Optional feature macro used by the top: ARITH_EXT_ARB_STATS_EN.
package arith_ext_arb_pkg;

  localparam int unsigned STATS_WIDTH = 32;
  localparam int unsigned MAX_REQ     = 64;
  localparam int unsigned MAX_IDX_W   = 6;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Requester index width, never below one bit.
  function automatic int unsigned tag_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First set bit of valid[n-1:0] searching ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input int unsigned        ptr,
                                       input int unsigned        n);
    rr_pick_t           r;
    logic [MAX_IDX_W:0] sum;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n && !r.found) begin
        // ptr < n, so one conditional subtraction replaces the modulo
        sum = (MAX_IDX_W+1)'(ptr) + (MAX_IDX_W+1)'(k);
        if (sum >= (MAX_IDX_W+1)'(n)) sum = sum - (MAX_IDX_W+1)'(n);
        if (valid[sum[MAX_IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = sum[MAX_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arith_ext_arbiter_unit.sv
// Combinational sign/zero extension of an IN_WIDTH operand to OUT_WIDTH.
module arith_ext_unit #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  i_operand,
  input  logic                 i_sext,
  output logic [OUT_WIDTH-1:0] o_result
);

  // Mask is all-ones when widths match, so the upper fill vanishes (pass-through).
  localparam logic [OUT_WIDTH-1:0] LOW_MASK = OUT_WIDTH'({IN_WIDTH{1'b1}});

  // Zero-extend, then fill the upper bits when sign-extending a negative operand.
  always_comb begin
    o_result = OUT_WIDTH'(i_operand);
    if (i_sext && i_operand[IN_WIDTH-1]) o_result = o_result | ~LOW_MASK;
  end

endmodule

// File: rtl/arith_ext_arbiter.sv
// Round-robin arbiter feeding one shared extension unit with a one-entry
// registered output. Define ARITH_EXT_ARB_STATS_EN to add the stall_cycles port.
module arith_ext_arbiter
  import arith_ext_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned TAG_WIDTH = tag_width(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          a_valid,
  output logic [NUM_REQ-1:0]          a_ready,
  input  logic [NUM_REQ*IN_WIDTH-1:0] a_data,
  input  logic [NUM_REQ-1:0]          a_signed,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [OUT_WIDTH-1:0]        result_data,
  output logic [TAG_WIDTH-1:0]        result_tag
`ifdef ARITH_EXT_ARB_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0]      stall_cycles
`endif
);

  logic [TAG_WIDTH-1:0] r_rr_ptr;
  logic                 r_result_valid;
  logic [OUT_WIDTH-1:0] r_result_data;
  logic [TAG_WIDTH-1:0] r_result_tag;

  logic [MAX_REQ-1:0]   w_valid_ext;
  rr_pick_t             w_pick;
  logic [TAG_WIDTH-1:0] w_grant;
  logic [TAG_WIDTH-1:0] w_ptr_nxt;
  logic                 w_can_load;
  logic                 w_xfer;
  logic [IN_WIDTH-1:0]  w_operand;
  logic                 w_sext;
  logic [OUT_WIDTH-1:0] w_ext;

  assign w_valid_ext = MAX_REQ'(a_valid);
  assign w_can_load  = !r_result_valid || result_ready;

  // Round-robin winner search from the current pointer.
  always_comb begin
    w_pick  = rr_pick(w_valid_ext, 32'(r_rr_ptr), NUM_REQ);
    w_grant = TAG_WIDTH'(w_pick.idx);
  end

  assign w_xfer    = rst_n && w_pick.found && w_can_load;
  assign w_ptr_nxt = (w_grant == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;

  // One-hot ready to the winner only; held low during reset.
  always_comb begin
    a_ready = '0;
    if (w_xfer) a_ready[w_grant] = 1'b1;
  end

  // Route the winner's operand and mode to the shared extension unit.
  always_comb begin
    w_operand = '0;
    w_sext    = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant == TAG_WIDTH'(i)) begin
        w_operand = a_data[i*IN_WIDTH +: IN_WIDTH];
        w_sext    = a_signed[i];
      end
    end
  end

  arith_ext_unit #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_ext (
    .i_operand(w_operand),
    .i_sext   (w_sext),
    .o_result (w_ext)
  );

  // Output register and pointer: load on transfer, drop valid on a bare pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr       <= '0;
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
      r_result_tag   <= '0;
    end else if (w_xfer) begin
      r_rr_ptr       <= w_ptr_nxt;
      r_result_valid <= 1'b1;
      r_result_data  <= w_ext;
      r_result_tag   <= w_grant;
    end else if (result_ready) begin
      r_result_valid <= 1'b0;
    end
  end

  assign result_valid = r_result_valid;
  assign result_data  = r_result_data;
  assign result_tag   = r_result_tag;

`ifdef ARITH_EXT_ARB_STATS_EN
  logic [STATS_WIDTH-1:0] r_stall_cycles;

  // Saturating count of cycles where a held result blocks waiting requesters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (r_result_valid && !result_ready && |a_valid && r_stall_cycles != '1) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_arith_ext_arbiter.sv
// Self-checking bench for arith_ext_arbiter (default parameters).
// Honours ARITH_EXT_ARB_STATS_EN when defined.
module tb_arith_ext_arbiter;

  localparam int N    = 4;
  localparam int IW   = 16;
  localparam int OW   = 32;
  localparam int TW   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      a_valid;
  logic [N-1:0]      a_ready;
  logic [N*IW-1:0]   a_data;
  logic [N-1:0]      a_signed;
  logic              result_valid;
  logic              result_ready;
  logic [OW-1:0]     result_data;
  logic [TW-1:0]     result_tag;
`ifdef ARITH_EXT_ARB_STATS_EN
  logic [31:0]       stall_cycles;
`endif

  always #5 clk = ~clk;

  arith_ext_arbiter #(
    .NUM_REQ  (N),
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .TAG_WIDTH(TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_data      (a_data),
    .a_signed    (a_signed),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_data (result_data),
    .result_tag  (result_tag)
`ifdef ARITH_EXT_ARB_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, updated from the behavioural rules at each edge.
  int          m_ptr   = 0;
  bit          m_valid = 0;
  logic [31:0] m_data  = '0;
  int          m_tag   = 0;
  longint      m_stall = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] op_of(input int i);
    logic [N*IW-1:0] d;
    d = a_data;
    return d[i*IW +: IW];
  endfunction

  // One clock: check outputs at the falling edge, advance model at the rising edge.
  task automatic cycle();
    int          g;
    bit          found;
    bit          can_load;
    logic [N-1:0] exp_rdy;
    logic [15:0] op;
    @(negedge clk);
    found = 0;
    g     = 0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (!found && a_valid[idx]) begin
        found = 1;
        g     = idx;
      end
    end
    can_load = !m_valid || result_ready;
    exp_rdy  = '0;
    if (rst_n && found && can_load) exp_rdy[g] = 1'b1;
    check("a_ready", 64'(a_ready), 64'(exp_rdy));
    check("a_ready_onehot0", 64'($onehot0(a_ready)), 64'd1);
    check("result_valid", 64'(result_valid), 64'(m_valid));
    check("result_data", 64'(result_data), 64'(m_data));
    check("result_tag", 64'(result_tag), 64'(m_tag));
`ifdef ARITH_EXT_ARB_STATS_EN
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_tag = 0; m_stall = 0;
    end else begin
      if (m_valid && !result_ready && (a_valid != 0) && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (found && can_load) begin
        op     = op_of(g);
        m_data = a_signed[g] ? 32'($signed(op)) : 32'(op);
        m_tag  = g;
        m_valid = 1;
        m_ptr  = (g + 1) % N;
      end else if (result_ready) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] v, input bit s);
    a_data[i*IW +: IW] = v;
    a_signed[i]        = s;
  endtask

  initial begin
    rst_n = 0; a_valid = '0; a_data = '0; a_signed = '0; result_ready = 1;
    #1;
    cycle(); cycle();
    rst_n = 1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) cycle();
    check("idle_valid", 64'(result_valid), 64'd0);

    // Single requester 2, sign- and zero-extension.
    set_op(2, 16'h8001, 1'b1); a_valid = 4'b0100;
    cycle();
    check("sext_data", 64'(result_data), 64'hFFFF_8001);
    check("sext_tag", 64'(result_tag), 64'd2);
    set_op(2, 16'h8001, 1'b0);
    cycle();
    check("zext_data", 64'(result_data), 64'h0000_8001);
    a_valid = '0;
    cycle();

    // Reset, then all requesters continuously valid: tags 0,1,2,3,0,...
    rst_n = 0; cycle(); rst_n = 1;
    for (int i = 0; i < N; i++) set_op(i, 16'(16'h7000 + i * 16'h1111), i[0]);
    a_valid = '1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("rr_tag_seq", 64'(result_tag), 64'(i % N));
      check("rr_valid", 64'(result_valid), 64'd1);
    end

    // Backpressure for three cycles, then release with no bubble.
    result_ready = 0;
    for (int i = 0; i < 3; i++) cycle();
    check("bp_tag_hold", 64'(result_tag), 64'd3);
`ifdef ARITH_EXT_ARB_STATS_EN
    check("bp_stall3", 64'(stall_cycles), 64'd3);
`endif
    result_ready = 1;
    cycle();
    check("release_tag", 64'(result_tag), 64'd0);
    check("release_valid", 64'(result_valid), 64'd1);

    // Only requesters 1 and 3: alternate, then only 1.
    a_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("alt_tag", 64'(result_tag), 64'((i % 2 == 0) ? 1 : 3));
    end
    a_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("solo_tag", 64'(result_tag), 64'd1);
    end

    // Reset while full.
    result_ready = 0;
    cycle();
    rst_n = 0; cycle(); rst_n = 1;
    check("rst_full_valid", 64'(result_valid), 64'd0);
    check("rst_full_tag", 64'(result_tag), 64'd0);
`ifdef ARITH_EXT_ARB_STATS_EN
    check("rst_stall0", 64'(stall_cycles), 64'd0);
`endif
    result_ready = 1;
    a_valid = '0;
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      a_valid      = N'($urandom);
      result_ready = ($urandom_range(0, 3) != 0);
      a_data       = {$urandom, $urandom};
      a_signed     = N'($urandom);
      rst_n        = ($urandom_range(0, 63) != 0);
      cycle();
    end
    rst_n = 1;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
